// File: rtl/axis_packet_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet FIFO.
package axis_packet_fifo_pkg;

  localparam int DROP_CNT_W   = 16;
  localparam int BEAT_TDATA_W = 8;
  localparam int BEAT_TUSER_W = 1;

  // Beat layout for the default one-byte, one-user-bit configuration.
  typedef struct packed {
    logic [BEAT_TDATA_W-1:0] tdata;
    logic                    tlast;
    logic [BEAT_TUSER_W-1:0] tuser;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int beat_w(input int bytes, input int user_bits);
    return bytes * 8 + 1 + user_bits;
  endfunction

endpackage

// File: rtl/axis_packet_fifo_sdp_ram.sv
// Simple dual-port RAM with one write port and a registered (1-cycle) read port.
module sdp_ram
  import axis_packet_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [addr_w(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [addr_w(DEPTH)-1:0]  rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and read register have no reset so the storage maps onto block RAM;
  // the surrounding pointer logic guarantees no stale entry is ever consumed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO with occupancy and packet-count status.
// Define AXIS_PACKET_FIFO_DROP_EN to drop bad (tuser[0]) and overflowing packets.
module axis_packet_fifo
  import axis_packet_fifo_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int DEPTH          = 1024
) (
  input  logic                        clk,
  input  logic                        aresetn,
  output logic                        axis_i_tready,
  input  logic                        axis_i_tvalid,
  input  logic                        axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]     axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]   axis_i_tuser,
  input  logic                        axis_o_tready,
  output logic                        axis_o_tvalid,
  output logic                        axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]     axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]   axis_o_tuser,
  output logic [addr_w(DEPTH):0]      level,
  output logic [addr_w(DEPTH):0]      packets,
  output logic [DROP_CNT_W-1:0]       drop_count
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PW     = ADDR_W + 1;
  localparam int DATA_W = AXIS_BYTES * 8;
  localparam int BW     = beat_w(AXIS_BYTES, AXIS_USER_BITS);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]         tdata;
    logic                      tlast;
    logic [AXIS_USER_BITS-1:0] tuser;
  } fifo_beat_t;

  logic [PW-1:0] wr_spec, wr_cmt, rd_ptr, fetch_ptr;
  logic [PW-1:0] wr_spec_nxt, wr_cmt_nxt, used;
  logic          full, rst_done, in_fire, wr_en, commit;
  logic          pop, issue, rd_pend, pf_valid, out_valid;
  logic [1:0]    stage_cnt;
  logic [BW-1:0] ram_rd;
  fifo_beat_t    ram_beat, pf_q, out_q;

  assign used    = wr_spec - rd_ptr;
  assign full    = (used == DEPTH_P);
  assign level   = used;
  assign in_fire = axis_i_tvalid && axis_i_tready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

`ifdef AXIS_PACKET_FIFO_DROP_EN
  logic                  ovf_q, bad_pkt, drop;
  logic [DROP_CNT_W-1:0] drop_q;

  assign axis_i_tready = rst_done;
  assign bad_pkt       = axis_i_tuser[0] || ovf_q || full;
  assign wr_en         = in_fire && !full;
  assign commit        = in_fire && axis_i_tlast && !bad_pkt;
  assign drop          = in_fire && axis_i_tlast && bad_pkt;
  assign drop_count    = drop_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_spec_nxt = wr_spec;
    wr_cmt_nxt  = wr_cmt;
    if (drop)       wr_spec_nxt = wr_cmt;
    else if (wr_en) wr_spec_nxt = wr_spec + 1'b1;
    if (commit)     wr_cmt_nxt  = wr_spec + 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (in_fire && axis_i_tlast) ovf_q <= 1'b0;
      else if (in_fire && full)    ovf_q <= 1'b1;
      if (drop && drop_q != '1)    drop_q <= drop_q + 1'b1;
    end
  end
`else
  logic cut_q, cut_start;

  assign axis_i_tready = rst_done && !full;
  assign wr_en         = in_fire;
  assign commit        = in_fire && axis_i_tlast;
  assign drop_count    = '0;
  // A full FIFO holding nothing but one unfinished packet would deadlock; release it
  // cut-through and keep the commit pointer tracking writes until its tlast.
  assign cut_start     = full && (wr_cmt == rd_ptr) && !cut_q;

  always_comb begin
    wr_spec_nxt = wr_en ? wr_spec + 1'b1 : wr_spec;
    wr_cmt_nxt  = wr_cmt;
    if (wr_en && (commit || cut_q)) wr_cmt_nxt = wr_spec + 1'b1;
    else if (cut_start)             wr_cmt_nxt = wr_spec;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)       cut_q <= 1'b0;
    else if (commit)    cut_q <= 1'b0;
    else if (cut_start) cut_q <= 1'b1;
  end
`endif

  // Read side: rd_ptr frees RAM entries only when a beat leaves the output register,
  // while fetch_ptr runs ahead into the prefetch/output stages.
  assign pop       = out_valid && axis_o_tready;
  assign stage_cnt = 2'(out_valid) + 2'(pf_valid) + 2'(rd_pend) - 2'(pop);
  assign issue     = (fetch_ptr != wr_cmt) && (stage_cnt < 2'd2);
  assign ram_beat  = ram_rd;

  sdp_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_spec[ADDR_W-1:0]),
    .wr_data ({axis_i_tdata, axis_i_tlast, axis_i_tuser}),
    .rd_en   (issue),
    .rd_addr (fetch_ptr[ADDR_W-1:0]),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_spec   <= '0;
      wr_cmt    <= '0;
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      rd_pend   <= 1'b0;
      packets   <= '0;
    end else begin
      wr_spec   <= wr_spec_nxt;
      wr_cmt    <= wr_cmt_nxt;
      rd_ptr    <= rd_ptr + PW'(pop);
      fetch_ptr <= fetch_ptr + PW'(issue);
      rd_pend   <= issue;
      case ({commit, pop && out_q.tlast})
        2'b10:   packets <= packets + 1'b1;
        2'b01:   packets <= packets - 1'b1;
        default: packets <= packets;
      endcase
    end
  end

  // Output register holds steady under back-pressure; the prefetch slot absorbs the
  // read already in flight so one beat per clock is sustained.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      pf_valid  <= 1'b0;
      pf_q      <= '0;
    end else if (!out_valid || pop) begin
      if (pf_valid) begin
        out_q     <= pf_q;
        out_valid <= 1'b1;
        pf_valid  <= rd_pend;
        if (rd_pend) pf_q <= ram_beat;
      end else if (rd_pend) begin
        out_q     <= ram_beat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (rd_pend) begin
      pf_q     <= ram_beat;
      pf_valid <= 1'b1;
    end
  end

  assign axis_o_tvalid = out_valid;
  assign axis_o_tlast  = out_q.tlast;
  assign axis_o_tdata  = out_q.tdata;
  assign axis_o_tuser  = out_q.tuser;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Scoreboard bench for axis_packet_fifo at DEPTH=16; honours AXIS_PACKET_FIFO_DROP_EN.
module tb_axis_packet_fifo;
  import axis_packet_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int PW    = addr_w(DEPTH) + 1;

  logic          clk = 1'b0, aresetn = 1'b0;
  logic          i_tready, i_tvalid = 1'b0, i_tlast = 1'b0;
  logic [7:0]    i_tdata = '0;
  logic [0:0]    i_tuser = '0;
  logic          o_tready = 1'b0, o_tvalid, o_tlast;
  logic [7:0]    o_tdata;
  logic [0:0]    o_tuser;
  logic [PW-1:0] level, packets;
  logic [15:0]   drop_count;

  int     checks = 0, errors = 0;
  beat_t  exp_q[$];
  bit     rand_rdy = 1'b0, gap_chk = 1'b0;
`ifdef AXIS_PACKET_FIFO_DROP_EN
  beat_t  pend_q[$];
  int     occ = 0, exp_drops = 0;
  bit     m_ovf = 1'b0;
`endif

  axis_packet_fifo #(
    .AXIS_BYTES (1), .AXIS_USER_BITS (1), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .aresetn (aresetn),
    .axis_i_tready (i_tready), .axis_i_tvalid (i_tvalid), .axis_i_tlast (i_tlast),
    .axis_i_tdata (i_tdata), .axis_i_tuser (i_tuser),
    .axis_o_tready (o_tready), .axis_o_tvalid (o_tvalid), .axis_o_tlast (o_tlast),
    .axis_o_tdata (o_tdata), .axis_o_tuser (o_tuser),
    .level (level), .packets (packets), .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a packet is delivered whole and in order unless it is dropped.
  task automatic model_accept(input beat_t b);
`ifdef AXIS_PACKET_FIFO_DROP_EN
    if (occ >= DEPTH) m_ovf = 1'b1;
    else begin pend_q.push_back(b); occ++; end
    if (b.tlast) begin
      if (m_ovf || b.tuser[0]) begin
        occ -= pend_q.size();
        exp_drops++;
      end else begin
        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      end
      pend_q.delete();
      m_ovf = 1'b0;
    end
`else
    exp_q.push_back(b);
`endif
  endtask

  task automatic model_flush();
    exp_q.delete();
`ifdef AXIS_PACKET_FIFO_DROP_EN
    pend_q.delete();
    occ   = 0;
    m_ovf = 1'b0;
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    int waited = 0;
    beat_t b;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; i_tuser = u;
    @(negedge clk);
    while (!i_tready && waited < 2000) begin @(negedge clk); waited++; end
    if (!i_tready) check("input_accept_timeout", 32'(waited), 32'd0);
    else begin
      b.tdata = d; b.tlast = l; b.tuser = u;
      model_accept(b);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit bad);
    for (int i = 0; i < n; i++) begin
      logic u;
`ifdef AXIS_PACKET_FIFO_DROP_EN
      u = bad && (i == n - 1);
`else
      u = 1'($urandom);
`endif
      send_beat(8'($urandom), i == n - 1, u);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || o_tvalid) && t < 5000) begin @(posedge clk); t++; end
    #1;
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial forever begin
    @(posedge clk); #2;
    if (rand_rdy) o_tready = 1'($urandom);
  end

  // Monitor: pops the scoreboard on every output handshake and polices AXI holds.
  initial begin
    bit    held = 1'b0, in_pkt = 1'b0;
    beat_t hb, got, e;
    forever begin
      @(negedge clk);
      if (!aresetn) begin held = 1'b0; in_pkt = 1'b0; continue; end
      got.tdata = o_tdata; got.tlast = o_tlast; got.tuser = o_tuser;
      if (held) begin
        check("tvalid_held", 32'(o_tvalid), 32'd1);
        check("beat_held", 32'(got), 32'(hb));
      end
      if (gap_chk && in_pkt) check("tvalid_mid_packet", 32'(o_tvalid), 32'd1);
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(got), 32'hDEAD);
        else begin
          e = exp_q.pop_front();
          check("out_beat", 32'(got), 32'(e));
        end
`ifdef AXIS_PACKET_FIFO_DROP_EN
        occ--;
`endif
        in_pkt = !o_tlast;
        held   = 1'b0;
      end else begin
        held = o_tvalid;
        hb   = got;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and tready rising on the first edge after release.
    repeat (3) @(posedge clk); #1;
    check("rst_i_tready", 32'(i_tready), 32'd0);
    check("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_packets", 32'(packets), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_o_tdata", 32'(o_tdata), 32'd0);
    aresetn = 1'b1;
    check("tready_before_edge", 32'(i_tready), 32'd0);
    @(posedge clk); #1;
    check("tready_after_edge", 32'(i_tready), 32'd1);

    // Single 3-beat packet: latency and packet count.
    o_tready = 1'b1;
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b1, 1'b0);
    check("lat_tvalid_n0", 32'(o_tvalid), 32'd0);
    check("lat_packets", 32'(packets), 32'd1);
    @(posedge clk); #1;
    check("lat_tvalid_n1", 32'(o_tvalid), 32'd0);
    @(posedge clk); #1;
    check("lat_tvalid_n2", 32'(o_tvalid), 32'd1);
    check("lat_first_data", 32'(o_tdata), 32'h11);
    wait_drain();
    check("single_packets_end", 32'(packets), 32'd0);

    // Continuous 4-beat packets against random back-pressure.
    gap_chk  = 1'b1;
    rand_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
`ifdef AXIS_PACKET_FIFO_DROP_EN
      for (int t = 0; t < 500 && level > PW'(DEPTH - 5); t++) begin @(posedge clk); #1; end
`endif
      send_pkt(4, 1'b0);
    end
    wait_drain();
    @(posedge clk); #1;
    rand_rdy = 1'b0;
    gap_chk  = 1'b0;
    o_tready = 1'b0;

    // Fill to DEPTH with four packets, then free one slot.
    for (int p = 0; p < 4; p++) send_pkt(4, 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_packets", 32'(packets), 32'd4);
`ifdef AXIS_PACKET_FIFO_DROP_EN
    check("full_tready", 32'(i_tready), 32'd1);
`else
    check("full_tready", 32'(i_tready), 32'd0);
`endif
    o_tready = 1'b1;
    @(posedge clk); #1;
    o_tready = 1'b0;
    check("one_pop_tready", 32'(i_tready), 32'd1);
    check("one_pop_level", 32'(level), 32'(DEPTH - 1));
    o_tready = 1'b1;
    wait_drain();
    check("fill_packets_end", 32'(packets), 32'd0);

`ifdef AXIS_PACKET_FIFO_DROP_EN
    // Bad-frame drop, overflow drop, then a good packet.
    o_tready = 1'b0;
    send_pkt(3, 1'b1);
    send_pkt(20, 1'b0);
    send_pkt(2, 1'b0);
    check("drop_count", 32'(drop_count), 32'd2);
    check("drop_count_model", 32'(drop_count), 32'(exp_drops));
    check("drop_level", 32'(level), 32'd2);
    check("drop_packets", 32'(packets), 32'd1);
    o_tready = 1'b1;
    wait_drain();
`else
    // Oversized packet with the output stalled must cut through.
    o_tready = 1'b0;
    fork
      send_pkt(20, 1'b0);
      begin
        for (int t = 0; t < 200 && level != PW'(DEPTH); t++) begin @(posedge clk); #1; end
        check("ct_level", 32'(level), 32'(DEPTH));
        repeat (5) @(posedge clk);
        #1;
        check("ct_tvalid", 32'(o_tvalid), 32'd1);
        check("ct_packets", 32'(packets), 32'd0);
        check("ct_tready", 32'(i_tready), 32'd0);
        o_tready = 1'b1;
      end
    join
    wait_drain();
    check("ct_packets_end", 32'(packets), 32'd0);
    check("drop_count_tied", 32'(drop_count), 32'd0);
`endif

    // Asynchronous reset with a committed packet and a partial one inside.
    o_tready = 1'b0;
    send_pkt(4, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(8'($urandom), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd7);
    @(posedge clk); #3;
    aresetn = 1'b0;
    model_flush();
    #1;
    check("arst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("arst_i_tready", 32'(i_tready), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_packets", 32'(packets), 32'd0);
    check("arst_o_tdata", 32'(o_tdata), 32'd0);
    check("arst_o_tlast", 32'(o_tlast), 32'd0);
    check("arst_o_tuser", 32'(o_tuser), 32'd0);
    check("arst_drop_count", 32'(drop_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tready", 32'(i_tready), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);
    o_tready = 1'b1;
    send_pkt(3, 1'b0);
    wait_drain();
    check("final_level", 32'(level), 32'd0);
    check("final_packets", 32'(packets), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
